cam_init_seq: RTL and testbench
===============================

CAM_INIT_SEQ -- requirements
Module: cam_init_seq

Interface
REQ-001 SHALL have parameter CLK_F, default 27_000_000, meaning i_clk frequency in Hz.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h21, meaning 7-bit SCCB device address (OV7670 write byte 0x42).
REQ-003 SHALL have parameter ROM_AW, default 8, meaning ROM address width; depth = 2**ROM_AW entries of 16 bits {reg, data}.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning extra attempts per entry after a NACK or verify mismatch.
REQ-005 SHALL have parameter VERIFY, default 0, meaning 1 = read back each written register and compare.
REQ-006 SHALL have parameter PWRUP_MS, default 10, meaning wait after start before the first entry.
REQ-007 i_clk  in  1  system clock; the only clock.
REQ-008 i_rstn  in  1  reset, asynchronous and active-low.
REQ-009 i_start  in  1  single-cycle pulse that begins or restarts a sequence.
REQ-010 o_rom_addr  out  ROM_AW  address to the synchronous ROM.
REQ-011 i_rom_data  in  16  ROM output, valid the cycle after o_rom_addr is presented.
REQ-012 o_i2c_start  out  1  one-cycle transaction request to the SCCB master.
REQ-013 o_i2c_dev / o_i2c_rd_wr / o_i2c_reg / o_i2c_wdata  out  7/1/8/8  transaction fields (rd_wr 1 = read).
REQ-014 i_i2c_ready / i_i2c_nack / i_i2c_rdata  in  1/1/8  master idle flag, NACK of the last transaction, read data.
REQ-015 o_busy / o_done / o_error  out  1/1/1  sequence active, completed cleanly, aborted.
REQ-016 o_err_index  out  ROM_AW  ROM index of the entry that caused o_error.

Function
REQ-017 SHALL use FSM states IDLE, PWRUP, FETCH, DECODE, DELAY, ISSUE, WAIT_LO, WAIT_HI, CHECK, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR + i_start: clear done/error, index=0, go to PWRUP; o_busy=1 in all states except IDLE/DONE/ERROR.
REQ-019 PWRUP SHALL count PWRUP_MS*(CLK_F/1000) cycles, then go to FETCH.
REQ-020 FETCH SHALL present the index for one cycle; DECODE SHALL sample i_rom_data the next cycle.
REQ-021 Entry 16'hFFFF SHALL end the sequence: DONE, o_done=1.
REQ-022 Entry {8'hFE, n} SHALL be a delay of n ms (n=0 means no delay); DELAY, then index+1, FETCH; no bus traffic.
REQ-023 Any other entry SHALL go to ISSUE, which waits for i_i2c_ready=1, then pulses o_i2c_start for exactly one cycle with fields held stable until WAIT_HI exits.
REQ-024 WAIT_LO SHALL wait for i_i2c_ready=0; WAIT_HI SHALL wait for i_i2c_ready=1, then sample i_i2c_nack/i_i2c_rdata into CHECK.
REQ-025 With VERIFY=1, each write SHALL be followed by a read of the same register (rd_wr=1); mismatch of rdata vs data counts as a failure.
REQ-026 On NACK or mismatch, the whole entry (write and readback) SHALL retry while retry count < MAX_RETRY; otherwise ERROR, o_error=1, o_err_index=index.
REQ-027 On success, retry count SHALL clear, index SHALL increment, and the FSM SHALL go to FETCH.
REQ-028 At index = 2**ROM_AW-1 without a terminator, completion of that entry SHALL go to DONE (no wrap).
REQ-029 i_start while busy SHALL be ignored except in PWRUP/DELAY, where it restarts PWRUP; never abort an in-flight bus transaction.
REQ-030 The ms tick counter SHALL be sized from CLK_F/1000 at elaboration; delay count SHALL be 8 bits.

Reset
REQ-031 Asynchronous assertion of i_rstn=0 SHALL force IDLE, index=0, retries=0, counters=0, and all outputs 0.
REQ-032 Reset released mid-sequence SHALL NOT auto-restart; a new i_start is required.

Structure
REQ-033 Shared package cam_pkg SHALL hold the state enum, END_MARK=16'hFFFF, DELAY_TAG=8'hFE, and the OV7670 default address.
REQ-034 One sub-module cam_ms_timer (ms tick + down-counter, used by PWRUP and DELAY) is natural; the ROM stays external.

Verification
REQ-035 ROM {12:80, 11:01, FFFF}, ack-always master model -> two writes (reg 0x12 data 0x80, reg 0x11 data 0x01) in order, then o_done=1, o_busy=0.
REQ-036 ROM {FE:05, 12:80, FFFF} at CLK_F=1000 kHz-scaled -> first o_i2c_start no earlier than (PWRUP_MS+5) ms after i_start.
REQ-037 NACK on every attempt at index 1, MAX_RETRY=3 -> exactly 4 attempts, then o_error=1, o_err_index=1, o_done=0.
REQ-038 VERIFY=1, model returns 0x00 once then correct data -> 2 write/read pairs for that entry, then sequence completes.
REQ-039 i_rstn pulsed low during WAIT_HI -> all outputs 0 immediately (asynchronous); no activity until next i_start, which restarts from index 0.
REQ-040 i_i2c_ready held 0 for 100 cycles in ISSUE -> o_i2c_start stays 0 until ready=1, then a single one-cycle pulse.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera register-init sequencer.
// Combinational-only declarations; no timing or flow control of its own.
package cam_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        DECODE,
        DELAY,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] END_MARK    = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG   = 8'hFE;
    localparam logic [6:0]  OV7670_ADDR = 7'h21;

endpackage

// File: rtl/cam_ms_timer.sv
// Millisecond down-counter: i_load arms it with i_ms, o_expired rises after i_ms*(CLK_F/1000) cycles.
// Reload takes effect the next cycle; no backpressure, i_load always wins.
module cam_ms_timer #(
    parameter int CLK_F = 27_000_000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_load,
    input  logic [7:0] i_ms,
    output logic       o_expired
);

    localparam int            TICK_DIV  = (CLK_F / 1000 > 0) ? CLK_F / 1000 : 1;
    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    ms_q, ms_d;

    always_comb begin
        tick_d = tick_q;
        ms_d   = ms_q;
        if (i_load) begin
            tick_d = '0;
            ms_d   = i_ms;
        end else if (ms_q != 8'd0) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                ms_d   = ms_q - 8'd1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tick_q <= '0;
            ms_q   <= '0;
        end else begin
            tick_q <= tick_d;
            ms_q   <= ms_d;
        end
    end

    assign o_expired = (ms_q == 8'd0);

endmodule

// File: rtl/cam_init_seq.sv
// Walks a {reg,data} ROM and issues SCCB writes (optional readback) with delays, retries and end marker.
// One ROM entry per FETCH/DECODE pair; stalls on i_i2c_ready, all outputs registered.
module cam_init_seq
    import cam_pkg::*;
#(
    parameter int         CLK_F     = 27_000_000,
    parameter logic [6:0] DEV_ADDR  = OV7670_ADDR,
    parameter int         ROM_AW    = 8,
    parameter int         MAX_RETRY = 3,
    parameter int         VERIFY    = 0,
    parameter int         PWRUP_MS  = 10
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_i2c_start,
    output logic [6:0]        o_i2c_dev,
    output logic              o_i2c_rd_wr,
    output logic [7:0]        o_i2c_reg,
    output logic [7:0]        o_i2c_wdata,
    input  logic              i_i2c_ready,
    input  logic              i_i2c_nack,
    input  logic [7:0]        i_i2c_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ROM_AW-1:0] o_err_index
);

    localparam int                RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [ROM_AW-1:0] LAST_IDX  = {ROM_AW{1'b1}};

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] idx_q, idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              start_q, start_d;
    logic [6:0]        dev_q, dev_d;
    logic              rd_q, rd_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              nack_q, nack_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ROM_AW-1:0] err_idx_q, err_idx_d;

    logic       tmr_load;
    logic [7:0] tmr_ms;
    logic       tmr_expired;
    logic       restart;
    logic       advance;
    logic       fail;

    cam_ms_timer #(
        .CLK_F (CLK_F)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_load    (tmr_load),
        .i_ms      (tmr_ms),
        .o_expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        start_d   = 1'b0;
        dev_d     = dev_q;
        rd_d      = rd_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        nack_d    = nack_q;
        rdata_d   = rdata_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        tmr_load  = 1'b0;
        tmr_ms    = 8'(PWRUP_MS);
        restart   = 1'b0;
        advance   = 1'b0;
        // a readback failure compares against the data that was just written
        fail      = nack_q | (rd_q & (rdata_q != wdata_q));

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) restart = 1'b1;
            end
            PWRUP: begin
                if (i_start)          restart = 1'b1;
                else if (tmr_expired) state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (i_rom_data == END_MARK) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (i_rom_data[15:8] == DELAY_TAG) begin
                    tmr_load = 1'b1;
                    tmr_ms   = i_rom_data[7:0];
                    state_d  = DELAY;
                end else begin
                    dev_d   = DEV_ADDR;
                    rd_d    = 1'b0;
                    reg_d   = i_rom_data[15:8];
                    wdata_d = i_rom_data[7:0];
                    state_d = ISSUE;
                end
            end
            DELAY: begin
                if (i_start)          restart = 1'b1;
                else if (tmr_expired) advance = 1'b1;
            end
            ISSUE: begin
                if (i_i2c_ready) begin
                    start_d = 1'b1;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!i_i2c_ready) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_i2c_ready) begin
                    nack_d  = i_i2c_nack;
                    rdata_d = i_i2c_rdata;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        rd_d    = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        state_d   = ERROR;
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                    end
                end else if (VERIFY != 0 && !rd_q) begin
                    rd_d    = 1'b1;
                    state_d = ISSUE;
                end else begin
                    retry_d = '0;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d   = PWRUP;
            idx_d     = '0;
            retry_d   = '0;
            done_d    = 1'b0;
            error_d   = 1'b0;
            err_idx_d = '0;
            tmr_load  = 1'b1;
            tmr_ms    = 8'(PWRUP_MS);
        end

        // the last ROM slot finishes the sequence instead of wrapping to 0
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + ROM_AW'(1);
                state_d = FETCH;
            end
        end

        busy_d = !(state_d inside {IDLE, DONE, ERROR});
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            start_q   <= 1'b0;
            dev_q     <= '0;
            rd_q      <= 1'b0;
            reg_q     <= '0;
            wdata_q   <= '0;
            nack_q    <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            start_q   <= start_d;
            dev_q     <= dev_d;
            rd_q      <= rd_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            nack_q    <= nack_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign o_rom_addr  = idx_q;
    assign o_i2c_start = start_q;
    assign o_i2c_dev   = dev_q;
    assign o_i2c_rd_wr = rd_q;
    assign o_i2c_reg   = reg_q;
    assign o_i2c_wdata = wdata_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;
    assign o_err_index = err_idx_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq: SCCB master/ROM models plus a sequence-level expectation model.
`timescale 1ns/1ps
module tb_cam_init_seq;

    localparam int CLK_F     = 10_000;
    localparam int ROM_AW    = 4;
    localparam int MAX_RETRY = 3;
    localparam int VERIFY    = 1;
    localparam int PWRUP_MS  = 2;

    logic              clk   = 1'b0;
    logic              rstn  = 1'b1;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              i2c_start;
    logic [6:0]        i2c_dev;
    logic              i2c_rd;
    logic [7:0]        i2c_reg;
    logic [7:0]        i2c_wdata;
    logic              i2c_ready = 1'b1;
    logic              i2c_nack  = 1'b0;
    logic [7:0]        i2c_rdata = 8'h00;
    logic              busy;
    logic              done;
    logic              error;
    logic [ROM_AW-1:0] err_index;

    always #5 clk = ~clk;

    cam_init_seq #(
        .CLK_F     (CLK_F),
        .DEV_ADDR  (7'h21),
        .ROM_AW    (ROM_AW),
        .MAX_RETRY (MAX_RETRY),
        .VERIFY    (VERIFY),
        .PWRUP_MS  (PWRUP_MS)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_i2c_start (i2c_start),
        .o_i2c_dev   (i2c_dev),
        .o_i2c_rd_wr (i2c_rd),
        .o_i2c_reg   (i2c_reg),
        .o_i2c_wdata (i2c_wdata),
        .i_i2c_ready (i2c_ready),
        .i_i2c_nack  (i2c_nack),
        .i_i2c_rdata (i2c_rdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_err_index (err_index)
    );

    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic       rd;
        logic [7:0] rg;
        logic [7:0] dat;
    } txn_t;

    txn_t exp_q[$];
    txn_t log_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SCCB master / camera model: 3-cycle transactions, register file, injectable NACK and bad readback
    logic [7:0] regs [256];
    int busy_cnt    = 0;
    int nack_reg    = -1;
    int corrupt_reg = -1;
    int corrupt_cnt = 0;
    bit hold_lo     = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) busy_cnt--;
            if (i2c_start) begin
                txn_t t;
                t.rd  = i2c_rd;
                t.rg  = i2c_reg;
                t.dat = i2c_wdata;
                log_q.push_back(t);
                busy_cnt = 3;
                i2c_nack = (int'(i2c_reg) == nack_reg);
                if (!i2c_rd && !i2c_nack) regs[i2c_reg] = i2c_wdata;
                if (i2c_rd) begin
                    if (int'(i2c_reg) == corrupt_reg && corrupt_cnt > 0) begin
                        corrupt_cnt--;
                        i2c_rdata = 8'h00;
                    end else begin
                        i2c_rdata = regs[i2c_reg];
                    end
                end
            end
            i2c_ready = (busy_cnt == 0) && !hold_lo;
        end
    end

    // Sequence-level model: list of bus transactions and final status implied by ROM + camera behaviour
    task automatic build_model(output bit ed, output bit ee, output int ei);
        int  cc;
        bit  ok;
        cc = corrupt_cnt;
        exp_q.delete();
        ed = 1'b0; ee = 1'b0; ei = 0;
        for (int i = 0; i < 16; i++) begin
            if (rom[i] == 16'hFFFF) begin
                ed = 1'b1;
                return;
            end
            if (rom[i][15:8] != 8'hFE) begin
                ok = 1'b0;
                for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
                    exp_q.push_back('{1'b0, rom[i][15:8], rom[i][7:0]});
                    if (int'(rom[i][15:8]) == nack_reg) continue;
                    if (VERIFY == 0) begin
                        ok = 1'b1;
                        continue;
                    end
                    exp_q.push_back('{1'b1, rom[i][15:8], rom[i][7:0]});
                    if (int'(rom[i][15:8]) == corrupt_reg && cc > 0) begin
                        cc--;
                        continue;
                    end
                    ok = 1'b1;
                end
                if (!ok) begin
                    ee = 1'b1;
                    ei = i;
                    return;
                end
            end
        end
        ed = 1'b1;
    endtask

    // Per-cycle compare process
    initial begin
        bit          prev_rdy = 1'b1;
        bit          stab     = 1'b0;
        logic [23:0] cap      = '0;
        txn_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                stab = 1'b0;
            end else begin
                if (stab && !i2c_start)
                    chk("field_hold", {i2c_dev, i2c_rd, i2c_reg, i2c_wdata}, cap);
                if (busy_cnt == 0) stab = 1'b0;
                if (i2c_start) begin
                    chk("start_when_ready", prev_rdy, 1);
                    chk("txn_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("txn_dev", i2c_dev, 7'h21);
                        chk("txn_rd", i2c_rd, e.rd);
                        chk("txn_reg", i2c_reg, e.rg);
                        if (!e.rd) chk("txn_wdata", i2c_wdata, e.dat);
                    end
                    cap  = {i2c_dev, i2c_rd, i2c_reg, i2c_wdata};
                    stab = 1'b1;
                end
                chk("status_excl", {done & busy, done & error, busy & error}, 0);
            end
            prev_rdy = i2c_ready;
        end
    end

    task automatic set_rom3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = a; rom[1] = b; rom[2] = c;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) @(negedge clk);
        chk("seq_finished", busy, 0);
    endtask

    task automatic end_checks(input bit ed, input bit ee, input int ei);
        chk("exp_drained", exp_q.size(), 0);
        chk("done", done, ed);
        chk("error", error, ee);
        if (ee) chk("err_index", err_index, ei);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_start"}, i2c_start, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_err_index"}, err_index, 0);
        chk({tag, "_fields"}, {i2c_dev, i2c_rd, i2c_reg, i2c_wdata}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ed, ee;
        int ei, c, n;

        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        #3 rstn = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("post_reset");

        // two writes with readback, then terminator
        set_rom3(16'h1280, 16'h1101, 16'hFFFF);
        build_model(ed, ee, ei);
        chk("t1_model_len", exp_q.size(), 4);
        chk("t1_model_done", ed, 1);
        log_q.delete();
        pulse_start();
        wait_idle(1000);
        end_checks(ed, ee, ei);
        chk("t1_log_len", log_q.size(), 4);
        chk("t1_first_write", {log_q[0].rd, log_q[0].rg, log_q[0].dat}, {1'b0, 8'h12, 8'h80});
        chk("t1_second_write", {log_q[2].rd, log_q[2].rg, log_q[2].dat}, {1'b0, 8'h11, 8'h01});
        chk("t1_reg12", regs[8'h12], 8'h80);
        chk("t1_reg11", regs[8'h11], 8'h01);

        // 5 ms delay entry ahead of the first write
        set_rom3(16'hFE05, 16'h1280, 16'hFFFF);
        build_model(ed, ee, ei);
        chk("t2_model_len", exp_q.size(), 2);
        pulse_start();
        c = 1;
        while (c < 300 && !i2c_start) begin
            @(negedge clk);
            c++;
        end
        chk("t2_delay_min", c >= (PWRUP_MS + 5) * (CLK_F / 1000), 1);
        chk("t2_delay_max", c <= 90, 1);
        wait_idle(1000);
        end_checks(ed, ee, ei);

        // index 1 always NACKs: four attempts then error
        set_rom3(16'h1280, 16'h1101, 16'hFFFF);
        nack_reg = 8'h11;
        build_model(ed, ee, ei);
        chk("t3_model_len", exp_q.size(), 6);
        chk("t3_model_err", {ee, 4'(ei)}, {1'b1, 4'd1});
        log_q.delete();
        pulse_start();
        wait_idle(1000);
        end_checks(ed, ee, ei);
        n = 0;
        foreach (log_q[i]) if (!log_q[i].rd && log_q[i].rg == 8'h11) n++;
        chk("t3_attempts", n, 4);
        chk("t3_err_index_lit", err_index, 1);
        nack_reg = -1;

        // first readback of reg 0x12 returns 0x00
        corrupt_reg = 8'h12;
        corrupt_cnt = 1;
        build_model(ed, ee, ei);
        chk("t4_model_len", exp_q.size(), 6);
        log_q.delete();
        pulse_start();
        wait_idle(1000);
        end_checks(ed, ee, ei);
        n = 0;
        foreach (log_q[i]) if (log_q[i].rg == 8'h12) n++;
        chk("t4_reg12_txns", n, 4);
        corrupt_reg = -1;

        // master not ready for a long time while the sequencer sits in ISSUE
        set_rom3(16'h1280, 16'hFFFF, 16'hFFFF);
        build_model(ed, ee, ei);
        hold_lo = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        n = 0;
        repeat (130) begin
            @(negedge clk);
            n += int'(i2c_start);
        end
        chk("t5_no_start_while_busy", n, 0);
        hold_lo = 1'b0;
        c = 0;
        while (c < 10 && !i2c_start) begin
            @(negedge clk);
            c++;
        end
        chk("t5_pulse_after_ready", i2c_start, 1);
        wait_idle(1000);
        end_checks(ed, ee, ei);

        // asynchronous reset while a transaction is in flight
        set_rom3(16'h1280, 16'h1101, 16'hFFFF);
        build_model(ed, ee, ei);
        pulse_start();
        c = 0;
        while (c < 300 && !i2c_start) begin
            @(negedge clk);
            c++;
        end
        chk("t6_reached_txn", i2c_start, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_zero("t6_async");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n += int'(i2c_start);
        end
        chk("t6_quiet_after_reset", n, 0);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_addr", rom_addr, 0);
        build_model(ed, ee, ei);
        log_q.delete();
        pulse_start();
        wait_idle(1000);
        end_checks(ed, ee, ei);
        chk("t6_restart_idx0", {log_q[0].rd, log_q[0].rg}, {1'b0, 8'h12});

        // full ROM without terminator; a start pulse mid-transaction is ignored
        for (int i = 0; i < 16; i++) rom[i] = {8'h30 + 8'(i), 8'h40 + 8'(i)};
        build_model(ed, ee, ei);
        chk("t7_model_len", exp_q.size(), 32);
        log_q.delete();
        pulse_start();
        c = 0;
        while (c < 300 && !i2c_start) begin
            @(negedge clk);
            c++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(3000);
        end_checks(ed, ee, ei);
        chk("t7_log_len", log_q.size(), 32);
        chk("t7_last_reg", log_q[31].rg, 8'h3F);
        chk("t7_done_lit", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
